// File: rtl/rvfi_mon_pkg.sv
// Shared types and helpers for the RVFI retirement-sequence monitor.
// The error codes below are the values reported on err_code.
package rvfi_mon_pkg;

    localparam int ORDER_W = 64;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        PC        = 3'd1,
        ORDER     = 3'd2,
        NONCONTIG = 3'd3,
        HALT      = 3'd4,
        STALL     = 3'd5,
        ALIGN     = 3'd6
    } err_code_e;

    // compressed=1 allows 2-byte aligned PCs; otherwise 4-byte alignment is required
    function automatic logic align_ok(input logic [1:0] pc_lsb, input logic compressed);
        return compressed ? !pc_lsb[0] : (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/rvfi_pc_seq_chk.sv
// Combinational check of one retirement channel against its predecessor.
// Priority within a channel: HALT > ORDER > PC > ALIGN.
module rvfi_pc_seq_chk
    import rvfi_mon_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int COMPRESSED = 1
) (
    input  logic               halted,
    input  logic               have_prev,
    input  logic [ORDER_W-1:0] prev_order,
    input  logic [XLEN-1:0]    prev_pc,
    input  logic [ORDER_W-1:0] order,
    input  logic [XLEN-1:0]    pc_rdata,
    input  logic [XLEN-1:0]    pc_wdata,
    input  logic               intr,
    output err_code_e          code,
    output logic [XLEN-1:0]    bad_pc
);

    always_comb begin
        code   = NONE;
        bad_pc = pc_rdata;
        if (halted) begin
            code = HALT;
        end else if (have_prev && (order != prev_order + ORDER_W'(1))) begin
            code = ORDER;
        end else if (have_prev && !intr && (pc_rdata != prev_pc)) begin
            code = PC;
        end else if (!align_ok(pc_rdata[1:0], COMPRESSED != 0)) begin
            code = ALIGN;
        end else if (!align_ok(pc_wdata[1:0], COMPRESSED != 0)) begin
            code   = ALIGN;
            bad_pc = pc_wdata;
        end
    end

endmodule

// File: rtl/rvfi_pc_seq_monitor.sv
// Multi-channel RVFI retirement-sequence monitor: chains per-channel checks and
// keeps history, the stall watchdog, the first-error latch and the retirement count.
module rvfi_pc_seq_monitor
    import rvfi_mon_pkg::*;
#(
    parameter int  NRET       = 1,
    parameter int  XLEN       = 32,
    parameter int  COMPRESSED = 1,
    parameter int  MAX_STALL  = 16,
    parameter int  CNT_W      = 32,
    localparam int CHW        = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_wdata,
    input  logic [NRET-1:0]         rvfi_trap,
    input  logic [NRET-1:0]         rvfi_halt,
    input  logic [NRET-1:0]         rvfi_intr,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic [CHW-1:0]          err_chan,
    output logic [ORDER_W-1:0]      err_order,
    output logic [XLEN-1:0]         err_pc_exp,
    output logic [XLEN-1:0]         err_pc_got,
    output logic [CNT_W-1:0]        retired
);

    localparam int            SW         = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [SW-1:0] STALL_MAX  = SW'(MAX_STALL);
    localparam logic [SW-1:0] STALL_LAST = (MAX_STALL > 0) ? SW'(MAX_STALL - 1) : '0;

    logic [ORDER_W-1:0] prev_order;
    logic [XLEN-1:0]    prev_pc;
    logic               have_prev;
    logic               halted;
    logic [SW-1:0]      stall_cnt;

    logic [ORDER_W-1:0] ch_order      [NRET];
    logic [ORDER_W-1:0] ch_prev_order [NRET];
    logic [XLEN-1:0]    ch_rpc        [NRET];
    logic [XLEN-1:0]    ch_wpc        [NRET];
    logic [XLEN-1:0]    ch_prev_pc    [NRET];
    logic [XLEN-1:0]    ch_bad_pc     [NRET];
    logic               ch_have_prev  [NRET];
    err_code_e          ch_code       [NRET];
    logic [NRET-1:0]    halt_before;
    logic               halt_seen;

    logic               gap, seen_hole;
    logic [CHW-1:0]     gap_chan;
    logic [ORDER_W-1:0] gap_order, last_order;
    logic [XLEN-1:0]    last_pc;
    logic               stall_inc, stall_hit, any_valid;

    logic               viol;
    err_code_e          v_code;
    logic [CHW-1:0]     v_chan;
    logic [ORDER_W-1:0] v_order;
    logic [XLEN-1:0]    v_exp, v_got;

    logic unused_trap;
    assign unused_trap = ^rvfi_trap;

    // Channel 0 compares against the registered history, higher channels against their neighbour
    for (genvar g = 0; g < NRET; g++) begin : g_ch
        assign ch_order[g] = rvfi_order[g*ORDER_W +: ORDER_W];
        assign ch_rpc[g]   = rvfi_pc_rdata[g*XLEN +: XLEN];
        assign ch_wpc[g]   = rvfi_pc_wdata[g*XLEN +: XLEN];
        if (g == 0) begin : g_first
            assign ch_prev_order[g] = prev_order;
            assign ch_prev_pc[g]    = prev_pc;
            assign ch_have_prev[g]  = have_prev;
        end else begin : g_next
            assign ch_prev_order[g] = ch_order[g-1];
            assign ch_prev_pc[g]    = ch_wpc[g-1];
            assign ch_have_prev[g]  = 1'b1;
        end
        rvfi_pc_seq_chk #(.XLEN(XLEN), .COMPRESSED(COMPRESSED)) u_chk (
            .halted    (halt_before[g]),
            .have_prev (ch_have_prev[g]),
            .prev_order(ch_prev_order[g]),
            .prev_pc   (ch_prev_pc[g]),
            .order     (ch_order[g]),
            .pc_rdata  (ch_rpc[g]),
            .pc_wdata  (ch_wpc[g]),
            .intr      (rvfi_intr[g]),
            .code      (ch_code[g]),
            .bad_pc    (ch_bad_pc[g])
        );
    end

    always_comb begin
        halt_seen   = halted;
        halt_before = '0;
        for (int i = 0; i < NRET; i++) begin
            halt_before[i] = halt_seen;
            halt_seen      = halt_seen | rvfi_halt[i];
        end
    end

    always_comb begin
        gap        = 1'b0;
        seen_hole  = 1'b0;
        gap_chan   = '0;
        gap_order  = '0;
        last_order = prev_order;
        last_pc    = prev_pc;
        for (int i = 0; i < NRET; i++) begin
            if (!rvfi_valid[i] && !seen_hole) begin
                seen_hole = 1'b1;
                gap_chan  = CHW'(i);
                gap_order = ch_order[i];
            end else if (rvfi_valid[i] && seen_hole) begin
                gap = 1'b1;
            end
            if (rvfi_valid[i]) begin
                last_order = ch_order[i];
                last_pc    = ch_wpc[i];
            end
        end
    end

    assign any_valid = |rvfi_valid;
    assign stall_inc = (MAX_STALL > 0) && enable && have_prev && !halted && !any_valid;
    // Fires only on the step into MAX_STALL so a saturated counter does not re-trigger after clear
    assign stall_hit = stall_inc && (stall_cnt == STALL_LAST);

    always_comb begin
        viol    = 1'b0;
        v_code  = NONE;
        v_chan  = '0;
        v_order = '0;
        v_exp   = '0;
        v_got   = '0;
        if (enable && gap) begin
            viol    = 1'b1;
            v_code  = NONCONTIG;
            v_chan  = gap_chan;
            v_order = gap_order;
        end else if (enable) begin
            for (int i = 0; i < NRET; i++) begin
                if (!viol && rvfi_valid[i] && (ch_code[i] != NONE)) begin
                    viol    = 1'b1;
                    v_code  = ch_code[i];
                    v_chan  = CHW'(i);
                    v_order = ch_order[i];
                    v_exp   = ch_prev_pc[i];
                    v_got   = ch_bad_pc[i];
                end
            end
            if (stall_hit) begin
                viol    = 1'b1;
                v_code  = STALL;
                v_order = prev_order;
                v_exp   = prev_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_order <= '0;
            prev_pc    <= '0;
            have_prev  <= 1'b0;
            halted     <= 1'b0;
            stall_cnt  <= '0;
            retired    <= '0;
        end else begin
            if (enable && any_valid && !gap) begin
                prev_order <= last_order;
                prev_pc    <= last_pc;
                have_prev  <= 1'b1;
                halted     <= halted | (|(rvfi_valid & rvfi_halt));
            end
            if (clear || (enable && any_valid)) begin
                stall_cnt <= '0;
            end else if (stall_inc && (stall_cnt != STALL_MAX)) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
            if (enable) begin
                retired <= retired + CNT_W'($countones(rvfi_valid));
            end
        end
    end

    // A new violation beats a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err        <= 1'b0;
            err_code   <= '0;
            err_chan   <= '0;
            err_order  <= '0;
            err_pc_exp <= '0;
            err_pc_got <= '0;
        end else if (viol && (!err || clear)) begin
            err        <= 1'b1;
            err_code   <= v_code;
            err_chan   <= v_chan;
            err_order  <= v_order;
            err_pc_exp <= v_exp;
            err_pc_got <= v_got;
        end else if (clear) begin
            err        <= 1'b0;
            err_code   <= '0;
            err_chan   <= '0;
            err_order  <= '0;
            err_pc_exp <= '0;
            err_pc_got <= '0;
        end
    end

endmodule

// File: tb/tb_rvfi_pc_seq_monitor.sv
// Bench for rvfi_pc_seq_monitor: three configurations driven with directed steps,
// then a long randomized run of the single-channel DUT against a behavioural model.
module tb_rvfi_pc_seq_monitor;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // index 0: NRET=1 C=1 MAX_STALL=16; 1: NRET=2 MAX_STALL=0; 2: NRET=1 C=0 MAX_STALL=4
    logic         en    [3];
    logic         clr   [3];
    logic [1:0]   valid [3];
    logic [127:0] ord   [3];
    logic [63:0]  rpc   [3];
    logic [63:0]  wpc   [3];
    logic [1:0]   trap  [3];
    logic [1:0]   halt  [3];
    logic [1:0]   intr  [3];
    logic         err_o [3];
    logic [2:0]   code_o[3];
    logic         chan_o[3];
    logic [63:0]  eord_o[3];
    logic [31:0]  exp_o [3];
    logic [31:0]  got_o [3];
    logic [31:0]  ret_o [3];

    rvfi_pc_seq_monitor #(.NRET(1), .XLEN(32), .COMPRESSED(1), .MAX_STALL(16), .CNT_W(32)) u_a (
        .clk(clk), .resetn(resetn), .enable(en[0]), .clear(clr[0]),
        .rvfi_valid(valid[0][0:0]), .rvfi_order(ord[0][63:0]),
        .rvfi_pc_rdata(rpc[0][31:0]), .rvfi_pc_wdata(wpc[0][31:0]),
        .rvfi_trap(trap[0][0:0]), .rvfi_halt(halt[0][0:0]), .rvfi_intr(intr[0][0:0]),
        .err(err_o[0]), .err_code(code_o[0]), .err_chan(chan_o[0]), .err_order(eord_o[0]),
        .err_pc_exp(exp_o[0]), .err_pc_got(got_o[0]), .retired(ret_o[0])
    );

    rvfi_pc_seq_monitor #(.NRET(2), .XLEN(32), .COMPRESSED(1), .MAX_STALL(0), .CNT_W(32)) u_b (
        .clk(clk), .resetn(resetn), .enable(en[1]), .clear(clr[1]),
        .rvfi_valid(valid[1]), .rvfi_order(ord[1]),
        .rvfi_pc_rdata(rpc[1]), .rvfi_pc_wdata(wpc[1]),
        .rvfi_trap(trap[1]), .rvfi_halt(halt[1]), .rvfi_intr(intr[1]),
        .err(err_o[1]), .err_code(code_o[1]), .err_chan(chan_o[1]), .err_order(eord_o[1]),
        .err_pc_exp(exp_o[1]), .err_pc_got(got_o[1]), .retired(ret_o[1])
    );

    rvfi_pc_seq_monitor #(.NRET(1), .XLEN(32), .COMPRESSED(0), .MAX_STALL(4), .CNT_W(32)) u_c (
        .clk(clk), .resetn(resetn), .enable(en[2]), .clear(clr[2]),
        .rvfi_valid(valid[2][0:0]), .rvfi_order(ord[2][63:0]),
        .rvfi_pc_rdata(rpc[2][31:0]), .rvfi_pc_wdata(wpc[2][31:0]),
        .rvfi_trap(trap[2][0:0]), .rvfi_halt(halt[2][0:0]), .rvfi_intr(intr[2][0:0]),
        .err(err_o[2]), .err_code(code_o[2]), .err_chan(chan_o[2]), .err_order(eord_o[2]),
        .err_pc_exp(exp_o[2]), .err_pc_got(got_o[2]), .retired(ret_o[2])
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b1; clr[d] = 1'b0; valid[d] = '0; ord[d] = '0;
            rpc[d] = '0; wpc[d] = '0; trap[d] = '0; halt[d] = '0; intr[d] = '0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_all();
        step();
        resetn = 1'b1;
    endtask

    task automatic ret1(input int d, input logic [63:0] o, input logic [31:0] r, input logic [31:0] w,
                        input logic it, input logic hl);
        valid[d] = 2'b01; ord[d] = {64'd0, o}; rpc[d] = {32'd0, r}; wpc[d] = {32'd0, w};
        intr[d] = {1'b0, it}; halt[d] = {1'b0, hl};
    endtask

    // Behavioural model of the single-channel DUT (index 0)
    logic        m_have, m_halted, m_err;
    logic [63:0] m_prev_order, m_order;
    logic [31:0] m_prev_pc, m_exp, m_got, m_ret;
    int          m_idle, m_code;

    task automatic model_reset();
        m_have = 0; m_halted = 0; m_err = 0; m_prev_order = 0; m_order = 0;
        m_prev_pc = 0; m_exp = 0; m_got = 0; m_ret = 0; m_idle = 0; m_code = 0;
    endtask

    task automatic model_step();
        logic v; logic [63:0] o, eo; logic [31:0] r, w, ex, gt; int c;
        v = valid[0][0]; o = ord[0][63:0]; r = rpc[0][31:0]; w = wpc[0][31:0];
        c = 0; eo = 0; ex = 0; gt = 0;
        if (en[0] && v) begin
            eo = o; ex = m_prev_pc; gt = r;
            if (m_halted) c = 4;
            else if (m_have && o != m_prev_order + 64'd1) c = 2;
            else if (m_have && !intr[0][0] && r != m_prev_pc) c = 1;
            else if (r[0]) c = 6;
            else if (w[0]) begin c = 6; gt = w; end
        end else if (en[0] && m_have && !m_halted && m_idle == 15) begin
            c = 5; eo = m_prev_order; ex = m_prev_pc; gt = 0;
        end
        if (c != 0 && (!m_err || clr[0])) begin
            m_err = 1; m_code = c; m_order = eo; m_exp = ex; m_got = gt;
        end else if (clr[0]) begin
            m_err = 0; m_code = 0; m_order = 0; m_exp = 0; m_got = 0;
        end
        if (en[0] && v) begin
            m_have = 1; m_prev_order = o; m_prev_pc = w; m_halted = m_halted | halt[0][0];
            m_idle = 0; m_ret = m_ret + 32'd1;
        end else if (en[0] && m_have && !m_halted && m_idle < 16) begin
            m_idle++;
        end
        if (clr[0]) m_idle = 0;
    endtask

    initial begin
        logic [63:0] o;
        logic [31:0] r, w;
        logic        it;
        int          pick;

        resetn = 1'b0;
        idle_all();
        step(); step();
        check("rst_err",   err_o[0],  0);
        check("rst_code",  code_o[0], 0);
        check("rst_chan",  chan_o[0], 0);
        check("rst_order", eord_o[0], 0);
        check("rst_exp",   exp_o[0],  0);
        check("rst_got",   got_o[0],  0);
        check("rst_ret",   ret_o[0],  0);
        resetn = 1'b1;

        // Sequential retirements, then a PC discontinuity
        ret1(0, 1, 32'h0, 32'h4, 0, 0);  step();
        ret1(0, 2, 32'h4, 32'h8, 0, 0);  step();
        ret1(0, 3, 32'h8, 32'h10, 0, 0); step();
        check("seq_err", err_o[0], 0);
        check("seq_ret", ret_o[0], 3);
        ret1(0, 4, 32'h14, 32'h18, 0, 0); step(); valid[0] = 0;
        check("pc_err",  err_o[0],  1);
        check("pc_code", code_o[0], 1);
        check("pc_exp",  exp_o[0],  32'h10);
        check("pc_got",  got_o[0],  32'h14);
        clr[0] = 1; step(); clr[0] = 0;
        check("clr_err",  err_o[0],  0);
        check("clr_code", code_o[0], 0);
        check("clr_ret",  ret_o[0],  4);
        ret1(0, 5, 32'h40, 32'h44, 1, 0); step(); valid[0] = 0; intr[0] = 0;
        check("intr_err", err_o[0], 0);
        ret1(0, 7, 32'h44, 32'h48, 0, 0); step(); valid[0] = 0;
        check("ord_code",  code_o[0], 2);
        check("ord_order", eord_o[0], 7);

        // Two channels: legal wide retire, a gap, then a halt seen by channel 1
        do_reset();
        valid[1] = 2'b11; ord[1] = {64'd2, 64'd1}; rpc[1] = {32'h4, 32'h0}; wpc[1] = {32'h8, 32'h4};
        step(); valid[1] = 0;
        check("wide_err", err_o[1], 0);
        check("wide_ret", ret_o[1], 2);
        valid[1] = 2'b10; ord[1] = {64'd4, 64'd3}; rpc[1] = {32'hc, 32'h8}; wpc[1] = {32'h10, 32'hc};
        step(); valid[1] = 0;
        check("gap_err",  err_o[1],  1);
        check("gap_code", code_o[1], 3);
        check("gap_chan", chan_o[1], 0);
        check("gap_ret",  ret_o[1],  3);
        do_reset();
        valid[1] = 2'b11; halt[1] = 2'b01; ord[1] = {64'd2, 64'd1};
        rpc[1] = {32'h4, 32'h0}; wpc[1] = {32'h8, 32'h4};
        step(); idle_all();
        check("halt_code", code_o[1], 4);
        check("halt_chan", chan_o[1], 1);

        // Stall watchdog with MAX_STALL=4
        do_reset();
        ret1(2, 1, 32'h0, 32'h4, 0, 0); step(); valid[2] = 0;
        repeat (3) step();
        check("stall_early", err_o[2], 0);
        step();
        check("stall_err",   err_o[2],  1);
        check("stall_code",  code_o[2], 5);
        check("stall_order", eord_o[2], 1);
        check("stall_exp",   exp_o[2],  32'h4);
        check("stall_got",   got_o[2],  0);
        clr[2] = 1; step(); clr[2] = 0;
        check("stall_clr", err_o[2], 0);
        repeat (3) step();
        check("stall2_early", err_o[2], 0);
        step();
        check("stall2_code", code_o[2], 5);

        // Word alignment, then reset while the error is held
        do_reset();
        ret1(2, 1, 32'h100, 32'h102, 0, 0); step(); valid[2] = 0;
        check("align_code", code_o[2], 6);
        check("align_got",  got_o[2],  32'h102);
        resetn = 1'b0; #1;
        check("mrst_err",  err_o[2],  0);
        check("mrst_code", code_o[2], 0);
        check("mrst_got",  got_o[2],  0);
        check("mrst_ret",  ret_o[2],  0);
        step();
        resetn = 1'b1;

        // Randomized run of the single-channel DUT
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                model_reset();
                check("rnd_rst_err", err_o[0], 0);
                check("rnd_rst_ret", ret_o[0], 0);
                continue;
            end
            en[0]  = ($urandom_range(0, 9) != 0);
            clr[0] = ($urandom_range(0, 19) == 0);
            valid[0] = 0; intr[0] = 0; halt[0] = 0;
            if ($urandom_range(0, 9) < 7) begin
                o  = m_have ? m_prev_order + 64'd1
                            : (($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom});
                r  = m_have ? m_prev_pc : ($urandom & ~32'h1);
                it = 1'b0;
                pick = $urandom_range(0, 99);
                if (pick < 4) o = o + 64'd1;
                else if (pick < 8) begin r = $urandom & ~32'h1; it = 1'($urandom_range(0, 1)); end
                else if (pick == 8) r = r | 32'h1;
                pick = $urandom_range(0, 99);
                if (pick < 55) w = r + 32'd4;
                else if (pick < 75) w = r + 32'd2;
                else if (pick < 97) w = $urandom & ~32'h1;
                else w = $urandom | 32'h1;
                ret1(0, o, r, w, it, ($urandom_range(0, 299) == 0));
            end
            model_step();
            step();
            check("rnd_err",   err_o[0],  m_err);
            check("rnd_code",  code_o[0], m_code);
            check("rnd_chan",  chan_o[0], 0);
            check("rnd_order", eord_o[0], m_order);
            check("rnd_ret",   ret_o[0],  m_ret);
            if (m_code == 1 || m_code == 5) begin
                check("rnd_exp", exp_o[0], m_exp);
                check("rnd_got", got_o[0], m_got);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
